// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types: FSM states, flag indices, flags struct, opcodes
package alu_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - producer/consumer/status bundle of the ALU result stage
interface alu_result_stage_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) ();

  logic             in_valid_i;
  logic             in_ready_o;
  logic [N-1:0]     result_i;
  logic [3:0]       flags_i;
  logic             set_flags_i;
  logic             clr_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [N-1:0]     result_o;
  logic [3:0]       flags_o;
  logic [3:0]       status_o;
  logic             vsticky_o;
  logic [CNT_W-1:0] op_count_o;

  modport slave (
    input  in_valid_i, result_i, flags_i, set_flags_i, clr_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, flags_o, status_o, vsticky_o, op_count_o
  );

  modport master (
    output in_valid_i, result_i, flags_i, set_flags_i, clr_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, flags_o, status_o, vsticky_o, op_count_o
  );

endinterface

// File: rtl/alu_flag_reg.sv
// rtl/alu_flag_reg.sv - NZCV status register, sticky overflow and saturating op counter
module alu_flag_reg
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             accept_i,
  input  logic             set_flags_i,
  input  logic             clr_i,
  input  logic [3:0]       flags_i,
  output logic [3:0]       status_o,
  output logic             vsticky_o,
  output logic [CNT_W-1:0] op_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       status_q, status_d;
  logic             vsticky_q, vsticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    status_d  = status_q;
    vsticky_d = vsticky_q;
    cnt_d     = cnt_q;

    if (accept_i && set_flags_i) status_d = flags_i;

    // Set is applied after clear so a same-cycle overflow survives clr_i.
    if (clr_i) vsticky_d = 1'b0;
    if (accept_i && flags_i[FLAG_V]) vsticky_d = 1'b1;

    if (clr_i) begin
      cnt_d = accept_i ? CNT_ONE : '0;
    end else if (accept_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q  <= '0;
      vsticky_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      status_q  <= status_d;
      vsticky_q <= vsticky_d;
      cnt_q     <= cnt_d;
    end
  end

  assign status_o   = status_q;
  assign vsticky_o  = vsticky_q;
  assign op_count_o = cnt_q;

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - 2-entry result FIFO with status/sticky/counter side registers
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  alu_result_stage_if.slave bus
);

  state_e     state_q, state_d;
  logic [N-1:0] head_res_q, head_res_d;
  logic [N-1:0] tail_res_q, tail_res_d;
  alu_flags_t head_flg_q, head_flg_d;
  alu_flags_t tail_flg_q, tail_flg_d;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic emit;

  // Ready depends only on registered state (and reset), never on out_ready_i.
  assign in_ready  = rst_ni && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid_i && in_ready;
  assign emit      = out_valid && bus.out_ready_i;

  always_comb begin
    state_d    = state_q;
    head_res_d = head_res_q;
    head_flg_d = head_flg_q;
    tail_res_d = tail_res_q;
    tail_flg_d = tail_flg_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          head_res_d = bus.result_i;
          head_flg_d = bus.flags_i;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          head_res_d = bus.result_i;
          head_flg_d = bus.flags_i;
        end else if (accept) begin
          tail_res_d = bus.result_i;
          tail_flg_d = bus.flags_i;
          state_d    = FULL;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          head_res_d = tail_res_q;
          head_flg_d = tail_flg_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      head_res_q <= '0;
      head_flg_q <= '0;
      tail_res_q <= '0;
      tail_flg_q <= '0;
    end else begin
      state_q    <= state_d;
      head_res_q <= head_res_d;
      head_flg_q <= head_flg_d;
      tail_res_q <= tail_res_d;
      tail_flg_q <= tail_flg_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.result_o    = head_res_q;
  assign bus.flags_o     = head_flg_q;

  alu_flag_reg #(
    .CNT_W(CNT_W)
  ) u_flag_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .accept_i    (accept),
    .set_flags_i (bus.set_flags_i),
    .clr_i       (bus.clr_i),
    .flags_i     (bus.flags_i),
    .status_o    (bus.status_o),
    .vsticky_o   (bus.vsticky_o),
    .op_count_o  (bus.op_count_o)
  );

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed table-driven bench for alu_result_stage
module tb_alu_result_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_result_stage_if #(.N(4), .CNT_W(8)) bus  ();
  alu_result_stage_if #(.N(4), .CNT_W(2)) bus2 ();

  alu_result_stage #(.N(4), .CNT_W(8)) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  alu_result_stage #(.N(4), .CNT_W(2)) u_dut2 (
    .clk_i (clk),
    .rst_ni(rst2_n),
    .bus   (bus2)
  );

  typedef struct {
    logic       iv;
    logic [3:0] res;
    logic [3:0] fl;
    logic       sf;
    logic       clr;
    logic       ordy;
    logic       ov;
    logic [3:0] ro;
    logic [3:0] fo;
    logic       ir;
    logic [3:0] st;
    logic       vs;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic iv, logic [3:0] res, logic [3:0] fl, logic sf,
                              logic clr, logic ordy, logic ov, logic [3:0] ro,
                              logic [3:0] fo, logic ir, logic [3:0] st, logic vs,
                              logic [7:0] cnt);
    vec_t v;
    v.iv = iv; v.res = res; v.fl = fl; v.sf = sf; v.clr = clr; v.ordy = ordy;
    v.ov = ov; v.ro = ro; v.fo = fo; v.ir = ir; v.st = st; v.vs = vs; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive1(input logic iv, input logic [3:0] res, input logic [3:0] fl,
                        input logic sf, input logic clr, input logic ordy);
    bus.in_valid_i  = iv;
    bus.result_i    = res;
    bus.flags_i     = fl;
    bus.set_flags_i = sf;
    bus.clr_i       = clr;
    bus.out_ready_i = ordy;
  endtask

  task automatic drive2(input logic iv, input logic [3:0] res, input logic [3:0] fl,
                        input logic sf, input logic ordy);
    bus2.in_valid_i  = iv;
    bus2.result_i    = res;
    bus2.flags_i     = fl;
    bus2.set_flags_i = sf;
    bus2.clr_i       = 1'b0;
    bus2.out_ready_i = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //          iv res   fl     sf clr rdy  ov ro    fo     ir st     vs cnt
    vecs[0]  = mk(1, 4'h9, 4'h8, 1, 0, 1,   1, 4'h9, 4'h8, 1, 4'h8, 0, 8'd1);
    vecs[1]  = mk(0, 4'h0, 4'h0, 0, 0, 1,   0, 4'h0, 4'h0, 1, 4'h8, 0, 8'd1);
    vecs[2]  = mk(1, 4'h1, 4'h0, 0, 0, 0,   1, 4'h1, 4'h0, 1, 4'h8, 0, 8'd2);
    vecs[3]  = mk(1, 4'h2, 4'h4, 0, 0, 0,   1, 4'h1, 4'h0, 0, 4'h8, 0, 8'd3);
    vecs[4]  = mk(1, 4'h3, 4'h2, 0, 0, 0,   1, 4'h1, 4'h0, 0, 4'h8, 0, 8'd3);
    vecs[5]  = mk(1, 4'h3, 4'h2, 0, 0, 1,   1, 4'h2, 4'h4, 1, 4'h8, 0, 8'd3);
    vecs[6]  = mk(1, 4'h3, 4'h2, 0, 0, 1,   1, 4'h3, 4'h2, 1, 4'h8, 0, 8'd4);
    vecs[7]  = mk(0, 4'h0, 4'h0, 0, 0, 1,   0, 4'h0, 4'h0, 1, 4'h8, 0, 8'd4);
    vecs[8]  = mk(1, 4'h5, 4'h1, 0, 0, 1,   1, 4'h5, 4'h1, 1, 4'h8, 1, 8'd5);
    vecs[9]  = mk(1, 4'h6, 4'h1, 0, 1, 1,   1, 4'h6, 4'h1, 1, 4'h8, 1, 8'd1);
    vecs[10] = mk(0, 4'h0, 4'h0, 0, 1, 1,   0, 4'h0, 4'h0, 1, 4'h8, 0, 8'd0);
    vecs[11] = mk(1, 4'hA, 4'h6, 1, 0, 0,   1, 4'hA, 4'h6, 1, 4'h6, 0, 8'd1);
    vecs[12] = mk(0, 4'h0, 4'h0, 0, 0, 1,   0, 4'h0, 4'h0, 1, 4'h6, 0, 8'd1);
    vecs[13] = mk(0, 4'h0, 4'h0, 0, 0, 1,   0, 4'h0, 4'h0, 1, 4'h6, 0, 8'd1);

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    drive1(0, 4'h0, 4'h0, 0, 0, 0);
    drive2(0, 4'h0, 4'h0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    chk("rst_in_ready",  32'(bus.in_ready_o), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_result",    32'(bus.result_o), 32'd0);
    chk("rst_flags",     32'(bus.flags_o), 32'd0);
    chk("rst_status",    32'(bus.status_o), 32'd0);
    chk("rst_vsticky",   32'(bus.vsticky_o), 32'd0);
    chk("rst_count",     32'(bus.op_count_o), 32'd0);

    rst_n  = 1'b1;
    rst2_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      drive1(vecs[i].iv, vecs[i].res, vecs[i].fl, vecs[i].sf, vecs[i].clr, vecs[i].ordy);
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid_o), 32'(vecs[i].ov));
      chk($sformatf("v%0d_in_ready", i),  32'(bus.in_ready_o), 32'(vecs[i].ir));
      chk($sformatf("v%0d_status", i),    32'(bus.status_o), 32'(vecs[i].st));
      chk($sformatf("v%0d_vsticky", i),   32'(bus.vsticky_o), 32'(vecs[i].vs));
      chk($sformatf("v%0d_count", i),     32'(bus.op_count_o), 32'(vecs[i].cnt));
      if (vecs[i].ov) begin
        chk($sformatf("v%0d_result", i), 32'(bus.result_o), 32'(vecs[i].ro));
        chk($sformatf("v%0d_flags", i),  32'(bus.flags_o), 32'(vecs[i].fo));
      end
    end

    // Back-to-back streaming: each entry appears the cycle after it is offered.
    for (int i = 0; i < 10; i++) begin
      drive1(1, 4'(i), 4'h0, 0, 0, 1);
      step();
      chk($sformatf("stream%0d_valid", i),  32'(bus.out_valid_o), 32'd1);
      chk($sformatf("stream%0d_result", i), 32'(bus.result_o), 32'(i));
      chk($sformatf("stream%0d_ready", i),  32'(bus.in_ready_o), 32'd1);
      chk($sformatf("stream%0d_state", i),  32'(u_dut.state_q), 32'(ONE));
    end
    drive1(0, 4'h0, 4'h0, 0, 0, 1);
    step();
    chk("stream_drain_valid", 32'(bus.out_valid_o), 32'd0);
    chk("stream_count",       32'(bus.op_count_o), 32'd11);

    // Narrow counter saturation, then asynchronous reset while FULL.
    for (int i = 0; i < 5; i++) begin
      drive2(1, 4'(i), 4'hB, 1, 1);
      step();
    end
    chk("sat_count",   32'(bus2.op_count_o), 32'd3);
    chk("sat_status",  32'(bus2.status_o), 32'hB);
    chk("sat_vsticky", 32'(bus2.vsticky_o), 32'd1);

    drive2(1, 4'h7, 4'hB, 1, 0);
    step();
    drive2(0, 4'h0, 4'h0, 0, 0);
    chk("full_in_ready", 32'(bus2.in_ready_o), 32'd0);
    chk("full_valid",    32'(bus2.out_valid_o), 32'd1);
    chk("full_head",     32'(bus2.result_o), 32'd4);

    #2 rst2_n = 1'b0;
    #1;
    chk("arst_valid",    32'(bus2.out_valid_o), 32'd0);
    chk("arst_in_ready", 32'(bus2.in_ready_o), 32'd0);
    chk("arst_result",   32'(bus2.result_o), 32'd0);
    chk("arst_flags",    32'(bus2.flags_o), 32'd0);
    chk("arst_status",   32'(bus2.status_o), 32'd0);
    chk("arst_vsticky",  32'(bus2.vsticky_o), 32'd0);
    chk("arst_count",    32'(bus2.op_count_o), 32'd0);

    @(negedge clk);
    rst2_n = 1'b1;
    step();
    chk("arel_valid",    32'(bus2.out_valid_o), 32'd0);
    chk("arel_in_ready", 32'(bus2.in_ready_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter N, default 4, sets the ALU data width in bits.
REQ-002 Parameter CNT_W, default 8, sets the width of the operation counter.
REQ-003 clk_i  input  1  single clock; all state updates occur on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 in_valid_i  input  1  ALU output presented this cycle.
REQ-006 in_ready_o  output  1  stage can accept an entry.
REQ-007 result_i  input  N  ALU result_o.
REQ-008 flags_i  input  4  ALU {n_o, z_o, c_o, v_o}.
REQ-009 set_flags_i  input  1  accepted entry updates the status register.
REQ-010 clr_i  input  1  synchronous clear of the sticky overflow bit and the counter.
REQ-011 out_valid_o  output  1  head entry available.
REQ-012 out_ready_i  input  1  consumer takes the head entry.
REQ-013 result_o  output  N  head entry result.
REQ-014 flags_o  output  4  head entry flags {n,z,c,v}.
REQ-015 status_o  output  4  architectural NZCV register.
REQ-016 vsticky_o  output  1  sticky OR of every accepted v.
REQ-017 op_count_o  output  CNT_W  number of accepted entries, saturating.

Function
REQ-018 An entry is accepted when in_valid_i and in_ready_o are both high, and is emitted when out_valid_o and out_ready_i are both high.
REQ-019 Storage is a 2-entry FIFO controlled by an FSM with states EMPTY, ONE and FULL.
REQ-020 FSM transitions:
- EMPTY --accept--> ONE.
- ONE --accept only--> FULL.
- ONE --emit only--> EMPTY.
- ONE --accept and emit--> ONE.
- FULL --emit--> ONE.
- Otherwise, hold state.
REQ-021 in_ready_o = (state != FULL); it is registered-state only and has no combinational path from out_ready_i.
REQ-022 out_valid_o = (state != EMPTY); result_o and flags_o always show the oldest entry, driven directly from registers.
REQ-023 Latency: an entry accepted at edge k is visible on the outputs after edge k, with zero bubbles; sustained throughput is one entry per cycle when out_ready_i is held high.
REQ-024 Simultaneous accept and emit in ONE replaces the head in the same edge; FIFO order is preserved in all states.
REQ-025 status_o loads flags_i on an accept with set_flags_i=1; it is unchanged otherwise, independent of emission.
REQ-026 vsticky_o is set on an accept with flags_i[0]=1 and is cleared by clr_i; if both occur in the same cycle, set wins.
REQ-027 op_count_o increments by 1 per accept and saturates at 2^CNT_W-1 (no wrap); clr_i zeroes it, and clr_i together with an accept yields 1.
REQ-028 Emission while EMPTY and accept while FULL have no effect.
REQ-029 Output data when out_valid_o=0 holds its last value and is don't-care to consumers.

Reset
REQ-030 Asserting rst_ni low asynchronously forces the following, regardless of operation in progress:
- state to EMPTY;
- status_o, vsticky_o and op_count_o to 0;
- FIFO data registers to 0.
REQ-031 Reset values: in_ready_o=0 while rst_ni is low, then 1 after release; out_valid_o=0; result_o and flags_o are 0.
REQ-032 Reset mid-transfer discards all buffered entries; no partial entry survives.
REQ-033 Reset release is synchronised by the consumer system; the block takes no special action on release beyond resuming from EMPTY.

Structure
REQ-034 Shared package alu_pkg holds:
- the FSM state enum;
- the flag-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
- the flags struct;
- the existing ALU opcode definitions.
REQ-035 One sub-module, alu_flag_reg, implements status_o, vsticky_o and op_count_o; the FIFO and FSM reside in alu_result_stage.

Verification
REQ-036 Reset, then N=4, a single accept of result=4'h9, flags=4'b1000 with out_ready_i=1 -> out_valid_o=1 for exactly one cycle with result_o=9 and flags_o=8; op_count_o=1.
REQ-037 out_ready_i=0, then three offered entries 1, 2, 3 -> in_ready_o drops after 2; releasing out_ready_i emits 1, 2, 3 in order and 3 is accepted only once space frees.
REQ-038 Streaming 10 entries with out_ready_i=1 -> one entry per cycle with no bubbles, and the state stays in ONE.
REQ-039 Accept flags=4'b0001 with set_flags_i=0, then clr_i with a simultaneous v=1 accept -> status_o unchanged, vsticky_o=1, op_count_o=1.
REQ-040 CNT_W=2 with 5 accepts -> op_count_o=3; rst_ni pulsed low while FULL -> out_valid_o=0 immediately and all outputs 0.
